cond_logic: RTL and testbench
=============================

Name: cond_logic

Overview:
- Execute-stage conditional-execution unit for the ARM core.
- Owns the architectural NZCV flags register and evaluates each instruction's condition field against it through the existing condition checker.
- Gates the decoder's side-effect controls (PCSrc, RegWrite, MemWrite, flag write).
- Keeps saturating counters of executed and squashed instructions for performance debug.

Parameters:
- CNT_W, 32, width of the executed/squashed instruction counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous reset, active low.
- Valid  in  1  an instruction occupies the execute stage this cycle.
- Stall  in  1  execute stage held; the instruction must repeat next cycle.
- Cond  in  4  instruction condition field [31:28].
- ALUFlags  in  4  {N,Z,C,V} produced by the ALU this cycle.
- FlagW  in  2  [1]=write N,Z; [0]=write C,V (decoder, ungated).
- PCS  in  1  instruction writes PC (decoder, ungated).
- RegW  in  1  register write request (decoder, ungated).
- MemW  in  1  memory write request (decoder, ungated).
- NoWrite  in  1  compare-class op; suppress register write.
- Flags  out  4  current registered {N,Z,C,V}.
- CondEx  out  1  condition passes for the current instruction.
- PCSrc  out  1  gated PC write.
- RegWrite  out  1  gated register write.
- MemWrite  out  1  gated memory write.
- ExecCnt  out  CNT_W  instructions executed (condition passed).
- SquashCnt  out  CNT_W  instructions squashed (condition failed).

Behaviour:
- Reset (reset_n=0 at a rising edge): Flags=4'b0000, ExecCnt=0, SquashCnt=0.
  - Reset dominates every other input on that edge, including a mid-stall instruction.
  - Gated outputs are combinational and follow the rules below from reset onward.
- Condition evaluation is combinational from Cond and the registered Flags, via the condition-checker sub-module.
  - Codes 0000-1101 use standard ARM semantics.
  - 1110 (AL) gives CondEx=1.
  - 1111 gives CondEx=0. This is decided; the output is never X.
- Effective execute: Go = Valid & ~Stall & CondEx.
- Gated outputs, all combinational, zero latency:
  - PCSrc = PCS & Go.
  - RegWrite = RegW & ~NoWrite & Go.
  - MemWrite = MemW & Go.
  - When Valid=0 or Stall=1, all gated outputs are 0.
- Flag update at the rising edge:
  - If Go & FlagW[1]: N,Z <= ALUFlags[3:2].
  - If Go & FlagW[0]: C,V <= ALUFlags[1:0].
  - The two halves are independent. FlagW=2'b10 leaves C,V unchanged.
- Timing of flag visibility:
  - Updated flags are visible on Flags/CondEx from the next cycle.
  - An instruction's own flag write never affects its own CondEx.
  - A CMP followed back-to-back by a BEQ gives the BEQ the new Z.
- Counters, at the rising edge with Valid & ~Stall:
  - CondEx=1 increments ExecCnt; otherwise SquashCnt increments.
  - Both counters saturate at all-ones and do not wrap.
  - A stalled instruction is counted once, on its non-stalled cycle.
- Simultaneous events:
  - Stall=1 with a flag write pending: no update; the write is retried on the release cycle.
  - Valid=0 with any other inputs: no state change.

Decomposition:
- Shared package:
  - 4-bit condition-code constants (EQ..AL, NV=4'b1111).
  - Flag bit indices N=3, Z=2, C=1, V=0.
  - FlagW bit indices NZ=1, CV=0.
- Sub-module: instantiate the existing condition checker (condcheck) for CondEx.
  - Its 1111 case must resolve to 0; update its default arm to 1'b0 as part of this work.
  - Everything else lives in cond_logic: flags register, gating, counters.

Test Plan:
- Reset then idle:
  - reset_n=0 for 2 cycles, then Valid=0 for 3 cycles -> Flags=0000, counters 0, PCSrc/RegWrite/MemWrite=0 throughout.
- CMP then BEQ:
  - Cycle 0: Valid=1, Cond=1110, ALUFlags=0100, FlagW=11, NoWrite=1, RegW=1 -> RegWrite=0.
  - Cycle 1: Cond=0000, PCS=1 -> Flags=0100, CondEx=1, PCSrc=1. ExecCnt=2 after cycle 1.
- Partial flag write:
  - Flags=1111, then Cond=1110, FlagW=10, ALUFlags=0000 -> next Flags=0011.
- Squash:
  - Flags=0000, Cond=0000 (EQ), RegW=1, MemW=1, FlagW=11, ALUFlags=1111 -> RegWrite=MemWrite=0, Flags stay 0000, SquashCnt +1.
  - Cond=1111 -> CondEx=0, also squashed.
- Stall:
  - Valid=1, Stall=1 for 3 cycles with AL, FlagW=11, ALUFlags=1010 -> no output asserted, Flags unchanged, counters unchanged.
  - Stall drops -> Flags=1010 next cycle, ExecCnt +1 exactly once.
- Saturation and reset mid-run:
  - Force CNT_W=4, run 20 AL instructions -> ExecCnt holds 4'hF.
  - Assert reset_n=0 during a stalled flag-writing instruction -> Flags=0000, ExecCnt=0 next cycle.

Source files
------------

// File: rtl/cond_logic_pkg.sv
// rtl/cond_logic_pkg.sv - shared condition-code and flag index constants
package cond_logic_pkg;

   // ARM condition field encodings
   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   // Bit positions inside the {N,Z,C,V} flag vector
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Bit positions inside the decoder's FlagW field
   localparam int FW_NZ = 1;
   localparam int FW_CV = 0;

endpackage

// File: rtl/cond_logic_condcheck.sv
// rtl/cond_logic_condcheck.sv - combinational ARM condition checker
module condcheck
   import cond_logic_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic n, z, c, v, ge;

   assign n  = Flags[FLAG_N];
   assign z  = Flags[FLAG_Z];
   assign c  = Flags[FLAG_C];
   assign v  = Flags[FLAG_V];
   assign ge = (n == v);

   // Decode the condition field; the reserved 1111 code never executes
   always_comb begin
      CondEx = 1'b0;
      case (Cond)
         COND_EQ: CondEx = z;
         COND_NE: CondEx = ~z;
         COND_CS: CondEx = c;
         COND_CC: CondEx = ~c;
         COND_MI: CondEx = n;
         COND_PL: CondEx = ~n;
         COND_VS: CondEx = v;
         COND_VC: CondEx = ~v;
         COND_HI: CondEx = ~z & c;
         COND_LS: CondEx = z | ~c;
         COND_GE: CondEx = ge;
         COND_LT: CondEx = ~ge;
         COND_GT: CondEx = ~z & ge;
         COND_LE: CondEx = z | ~ge;
         COND_AL: CondEx = 1'b1;
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - execute-stage flags register, side-effect gating and counters
module cond_logic
   import cond_logic_pkg::*;
#(
   parameter int CNT_W = 32
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             Valid,
   input  logic             Stall,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NoWrite,
   output logic [3:0]       Flags,
   output logic             CondEx,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic [CNT_W-1:0] ExecCnt,
   output logic [CNT_W-1:0] SquashCnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [3:0]       flags_q;
   logic [CNT_W-1:0] exec_q;
   logic [CNT_W-1:0] squash_q;
   logic             issue;
   logic             go;

   // Condition is judged against the flags as they stood before this instruction
   condcheck u_condcheck (
      .Cond   (Cond),
      .Flags  (flags_q),
      .CondEx (CondEx)
   );

   assign issue = Valid & ~Stall;
   assign go    = issue & CondEx;

   // Gate decoder side effects; compare-class ops never write a register
   always_comb begin
      PCSrc    = PCS & go;
      RegWrite = RegW & ~NoWrite & go;
      MemWrite = MemW & go;
   end

   // NZ and CV halves update independently; a stalled write waits for release
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         flags_q <= 4'b0000;
      end else begin
         if (go & FlagW[FW_NZ]) begin
            flags_q[FLAG_N] <= ALUFlags[FLAG_N];
            flags_q[FLAG_Z] <= ALUFlags[FLAG_Z];
         end
         if (go & FlagW[FW_CV]) begin
            flags_q[FLAG_C] <= ALUFlags[FLAG_C];
            flags_q[FLAG_V] <= ALUFlags[FLAG_V];
         end
      end
   end

   // Saturating executed/squashed counters, counted once on the issuing cycle
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         exec_q   <= '0;
         squash_q <= '0;
      end else if (issue) begin
         if (CondEx) begin
            if (exec_q != CNT_MAX) exec_q <= exec_q + CNT_ONE;
         end else begin
            if (squash_q != CNT_MAX) squash_q <= squash_q + CNT_ONE;
         end
      end
   end

   assign Flags     = flags_q;
   assign ExecCnt   = exec_q;
   assign SquashCnt = squash_q;

endmodule

// File: tb/tb_cond_logic.sv
// tb/tb_cond_logic.sv - randomized and directed self-checking bench for cond_logic
module tb_cond_logic;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        Valid, Stall, PCS, RegW, MemW, NoWrite;
   logic [3:0]  Cond, ALUFlags;
   logic [1:0]  FlagW;

   logic [3:0]  Flags, Flags4;
   logic        CondEx, PCSrc, RegWrite, MemWrite;
   logic        CondEx4, PCSrc4, RegWrite4, MemWrite4;
   logic [31:0] ExecCnt, SquashCnt;
   logic [3:0]  ExecCnt4, SquashCnt4;

   int total = 0;
   int bad   = 0;

   logic [3:0] m_flags;
   longint     m_exec, m_sq, m_exec4, m_sq4;

   always #5 clk = ~clk;

   cond_logic #(.CNT_W(32)) dut (
      .clk(clk), .reset_n(reset_n), .Valid(Valid), .Stall(Stall), .Cond(Cond),
      .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
      .NoWrite(NoWrite), .Flags(Flags), .CondEx(CondEx), .PCSrc(PCSrc),
      .RegWrite(RegWrite), .MemWrite(MemWrite), .ExecCnt(ExecCnt), .SquashCnt(SquashCnt)
   );

   cond_logic #(.CNT_W(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .Valid(Valid), .Stall(Stall), .Cond(Cond),
      .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
      .NoWrite(NoWrite), .Flags(Flags4), .CondEx(CondEx4), .PCSrc(PCSrc4),
      .RegWrite(RegWrite4), .MemWrite(MemWrite4), .ExecCnt(ExecCnt4), .SquashCnt(SquashCnt4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ARM condition semantics written from the architecture manual's table
   function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cy && !z;
         4'd9:  return !cy || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic longint sat_inc(input longint x, input longint max);
      return (x >= max) ? max : x + 1;
   endfunction

   // Inputs are already applied at a negedge; check, take the edge, advance model
   task automatic run_cycle();
      bit rc, go;
      #1;
      rc = ref_cond(Cond, m_flags);
      go = Valid && !Stall && rc;
      check("flags",     Flags,      m_flags);
      check("condex",    CondEx,     rc);
      check("pcsrc",     PCSrc,      PCS && go);
      check("regwrite",  RegWrite,   RegW && !NoWrite && go);
      check("memwrite",  MemWrite,   MemW && go);
      check("exec",      ExecCnt,    m_exec[31:0]);
      check("squash",    SquashCnt,  m_sq[31:0]);
      check("exec4",     ExecCnt4,   m_exec4[31:0]);
      check("squash4",   SquashCnt4, m_sq4[31:0]);
      check("flags4",    Flags4,     m_flags);
      @(posedge clk);
      if (!reset_n) begin
         m_flags = 4'b0000; m_exec = 0; m_sq = 0; m_exec4 = 0; m_sq4 = 0;
      end else if (Valid && !Stall) begin
         if (go && FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
         if (go && FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
         if (rc) begin
            m_exec  = sat_inc(m_exec, 64'hFFFF_FFFF);
            m_exec4 = sat_inc(m_exec4, 15);
         end else begin
            m_sq  = sat_inc(m_sq, 64'hFFFF_FFFF);
            m_sq4 = sat_inc(m_sq4, 15);
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      reset_n = 1'b1; Valid = 1'b0; Stall = 1'b0; Cond = 4'he; ALUFlags = 4'h0;
      FlagW = 2'b00; PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
   endtask

   task automatic instr(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] af);
      idle_inputs();
      Valid = 1'b1; Cond = c; FlagW = fw; ALUFlags = af;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      run_cycle();
      run_cycle();
      reset_n = 1'b1;
   endtask

   longint base;

   initial begin
      m_flags = 4'bxxxx; m_exec = 0; m_sq = 0; m_exec4 = 0; m_sq4 = 0;
      idle_inputs();
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      m_flags = 4'b0000;

      // Reset then idle
      do_reset();
      for (int i = 0; i < 3; i++) run_cycle();
      check("rst_flags", Flags, 4'b0000);
      check("rst_exec", ExecCnt, 0);

      // CMP then BEQ
      instr(4'he, 2'b11, 4'b0100); NoWrite = 1'b1; RegW = 1'b1;
      #1 check("cmp_regwrite", RegWrite, 1'b0);
      run_cycle();
      instr(4'h0, 2'b00, 4'b0000); PCS = 1'b1;
      #1 check("beq_flags", Flags, 4'b0100);
      check("beq_condex", CondEx, 1'b1);
      check("beq_pcsrc", PCSrc, 1'b1);
      run_cycle();
      check("beq_exec", ExecCnt, 2);

      // Partial flag write
      instr(4'he, 2'b11, 4'b1111); run_cycle();
      instr(4'he, 2'b10, 4'b0000); run_cycle();
      idle_inputs(); #1 check("partial_flags", Flags, 4'b0011);
      run_cycle();

      // Squash on EQ with Z clear, then on NV
      instr(4'he, 2'b11, 4'b0000); run_cycle();
      base = m_sq;
      instr(4'h0, 2'b11, 4'b1111); RegW = 1'b1; MemW = 1'b1;
      #1 check("sq_regwrite", RegWrite, 1'b0);
      check("sq_memwrite", MemWrite, 1'b0);
      run_cycle();
      instr(4'hf, 2'b11, 4'b1111); RegW = 1'b1;
      #1 check("nv_condex", CondEx, 1'b0);
      run_cycle();
      check("sq_flags", Flags, 4'b0000);
      check("sq_count", SquashCnt, base + 2);

      // Stall for three cycles then release
      base = m_exec;
      for (int i = 0; i < 3; i++) begin
         instr(4'he, 2'b11, 4'b1010); Stall = 1'b1; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1;
         run_cycle();
      end
      check("stall_flags", Flags, 4'b0000);
      instr(4'he, 2'b11, 4'b1010); run_cycle();
      idle_inputs(); #1 check("rel_flags", Flags, 4'b1010);
      check("rel_exec", ExecCnt, base + 1);
      run_cycle();

      // Saturation of the narrow counter
      do_reset();
      for (int i = 0; i < 20; i++) begin instr(4'he, 2'b00, 4'h0); run_cycle(); end
      check("sat_exec4", ExecCnt4, 4'hf);
      check("sat_exec32", ExecCnt, 20);

      // Reset during a stalled flag-writing instruction
      instr(4'he, 2'b11, 4'b1010); Stall = 1'b1; run_cycle();
      instr(4'he, 2'b11, 4'b1010); Stall = 1'b1; reset_n = 1'b0; run_cycle();
      idle_inputs(); #1 check("midrst_flags", Flags, 4'b0000);
      check("midrst_exec", ExecCnt, 0);
      run_cycle();

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         reset_n  = ($urandom_range(0, 99) != 0);
         Valid    = ($urandom_range(0, 3) != 0);
         Stall    = ($urandom_range(0, 3) == 0);
         Cond     = 4'($urandom);
         ALUFlags = 4'($urandom);
         FlagW    = 2'($urandom);
         PCS      = 1'($urandom);
         RegW     = 1'($urandom);
         MemW     = 1'($urandom);
         NoWrite  = 1'($urandom);
         run_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
